// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of an asynchronous input over a GATE_CYCLES window
// and hands the count to the downstream BCD converter. Optional macro: FREQ_OVF_SAT_EN.
module freq_gate_counter #(
  parameter logic [31:0] GATE_CYCLES = 32'd100_000_000,
  parameter logic [31:0] MAX_COUNT   = 32'd999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig_in,
  input  logic        done,
  output logic [31:0] binary_out,
  output logic        start,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        sync1_r;
  logic        sync2_r;
  logic        sync3_r;
  logic        edge_s;
  logic        edge_inc_s;
  logic [31:0] gate_cnt_r;
  logic [31:0] edge_cnt_r;
  logic [31:0] binary_out_r;
  logic        start_r;
  logic        ovf_r;
  logic        gate_last_s;
  logic        count_en_s;
  logic [31:0] latch_sum_s;
  logic [31:0] latch_val_s;
  logic        latch_ovf_s;

  // Two-flop synchronizer plus a delay stage for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign edge_s      = sync2_r & ~sync3_r;
  assign latch_sum_s = edge_cnt_r + {31'd0, edge_s};

`ifdef FREQ_OVF_SAT_EN
  // Counter parks at MAX_COUNT+1 so it cannot wrap back into the valid range
  assign edge_inc_s  = edge_s & (edge_cnt_r <= MAX_COUNT);
  assign latch_ovf_s = (latch_sum_s > MAX_COUNT);
  assign latch_val_s = latch_ovf_s ? MAX_COUNT : latch_sum_s;
`else
  logic max_count_unused_s;
  assign max_count_unused_s = ^MAX_COUNT;
  assign edge_inc_s  = edge_s;
  assign latch_ovf_s = 1'b0;
  assign latch_val_s = latch_sum_s;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a low en wins over window completion and done
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_next_s = GATE;
        else    state_next_s = IDLE;
      end
      GATE: begin
        if (!en)                                   state_next_s = IDLE;
        else if (gate_cnt_r == GATE_CYCLES - 32'd1) state_next_s = WAIT;
        else                                       state_next_s = GATE;
      end
      WAIT: begin
        if (!en)       state_next_s = IDLE;
        else if (done) state_next_s = GATE;
        else           state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: counting enable and terminal-cycle strobe
  always_comb begin
    gate_last_s = 1'b0;
    count_en_s  = 1'b0;
    case (state_r)
      GATE: begin
        if (!en) begin
          gate_last_s = 1'b0;
          count_en_s  = 1'b0;
        end else if (gate_cnt_r == GATE_CYCLES - 32'd1) begin
          gate_last_s = 1'b1;
          count_en_s  = 1'b0;
        end else begin
          gate_last_s = 1'b0;
          count_en_s  = 1'b1;
        end
      end
      default: begin
        gate_last_s = 1'b0;
        count_en_s  = 1'b0;
      end
    endcase
  end

  // Window counters; cleared at window close so WAIT and IDLE hold them at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_r <= 32'd0;
      edge_cnt_r <= 32'd0;
    end else if (count_en_s) begin
      gate_cnt_r <= gate_cnt_r + 32'd1;
      edge_cnt_r <= edge_cnt_r + {31'd0, edge_inc_s};
    end else begin
      gate_cnt_r <= 32'd0;
      edge_cnt_r <= 32'd0;
    end
  end

  // Result latch and start strobe, updated only on the terminal GATE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_out_r <= 32'd0;
      ovf_r        <= 1'b0;
      start_r      <= 1'b0;
    end else if (gate_last_s) begin
      binary_out_r <= latch_val_s;
      ovf_r        <= latch_ovf_s;
      start_r      <= 1'b1;
    end else begin
      start_r      <= 1'b0;
    end
  end

  assign binary_out = binary_out_r;
  assign start      = start_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter with GATE_CYCLES=100, MAX_COUNT=20.
module tb_freq_gate_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sig_in;
  logic        done;
  logic [31:0] binary_out;
  logic        start;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          snap;
  logic [31:0] exp_bin_q[$];
  logic        exp_ovf_q[$];
  int          sig_period = 10;
  logic        sig_level = 1'b0;
  int          sig_epoch = 0;

  freq_gate_counter #(
    .GATE_CYCLES(32'd100),
    .MAX_COUNT  (32'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .done      (done),
    .binary_out(binary_out),
    .start     (start),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] b, input logic o);
    exp_bin_q.push_back(b);
    exp_ovf_q.push_back(o);
  endtask

  // Waits for start, checks its arrival latency and that it lasts one cycle
  task automatic wait_start(input int exp_lat, input string name);
    int  n;
    bit  found;
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (start === 1'b1) found = 1'b1;
    end
    chk({name, "_start_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({name, "_latency"}, n, exp_lat);
      cycles(1);
      chk({name, "_start_width"}, {31'd0, start}, 32'd0);
    end
  endtask

  task automatic give_done(input int delay);
    cycles(delay);
    done = 1'b1;
    cycles(1);
    done = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    done   = 1'b0;
    sig_in = 1'b0;

    fork
      begin : monitor
        logic [31:0] eb;
        logic        eo;
        forever begin
          @(negedge clk);
          if (start === 1'b1) begin
            start_cnt++;
            if (exp_bin_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_start: got start with binary_out=%0d expected no start", binary_out);
            end else begin
              eb = exp_bin_q.pop_front();
              eo = exp_ovf_q.pop_front();
              chk("sb_binary_out", binary_out, eb);
              chk("sb_ovf", {31'd0, ovf}, {31'd0, eo});
            end
          end
        end
      end
      begin : generator
        int ph;
        int seen;
        ph = 0;
        seen = 0;
        forever begin
          @(posedge clk);
          #2;
          if (seen != sig_epoch) begin
            seen = sig_epoch;
            ph = 0;
          end
          if (sig_period == 0) begin
            sig_in = sig_level;
          end else begin
            sig_in = (ph < sig_period / 2);
            ph = (ph + 1 == sig_period) ? 0 : ph + 1;
          end
        end
      end
    join_none

    // Reset state
    cycles(3);
    chk("rst_binary_out", binary_out, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // 1: basic window, period 10 -> 10 edges
    en = 1'b1;
    push_exp(32'd10, 1'b0);
    wait_start(101, "w1");
    push_exp(32'd10, 1'b0);
    give_done(4);
    wait_start(100, "w2");

    // 2: done withheld for 300 cycles
    snap = start_cnt;
    cycles(300);
    chk("hold_start_cnt", start_cnt, snap);
    chk("hold_binary_out", binary_out, 32'd10);
    push_exp(32'd10, 1'b0);
    give_done(0);
    wait_start(100, "w3");

    // 3: period 2 -> 50 edges per window
    sig_period = 2;
    sig_epoch++;
`ifdef FREQ_OVF_SAT_EN
    push_exp(32'd20, 1'b1);
`else
    push_exp(32'd50, 1'b0);
`endif
    give_done(4);
    wait_start(100, "w4");

    // 4: asynchronous reset at cycle 60 of a window
    sig_period = 10;
    sig_epoch++;
    give_done(4);
    cycles(60);
    snap = start_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_binary_out", binary_out, 32'd0);
    chk("arst_start", {31'd0, start}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    sig_period = 0;
    sig_level = 1'b0;
    sig_epoch++;
    cycles(5);
    chk("arst_no_start", start_cnt, snap);
    push_exp(32'd10, 1'b0);
    sig_period = 10;
    sig_epoch++;
    rst_n = 1'b1;
    wait_start(101, "w_after_rst");

    // 5: en dropped at cycle 50 of the second window
    give_done(4);
    cycles(50);
    en = 1'b0;
    snap = start_cnt;
    cycles(150);
    chk("en_drop_no_start", start_cnt, snap);
    chk("en_drop_binary_out", binary_out, 32'd10);
    push_exp(32'd10, 1'b0);
    en = 1'b1;
    wait_start(101, "w_after_en");

    // 6: constant input levels still produce start with a zero count
    sig_period = 0;
    sig_level = 1'b1;
    sig_epoch++;
    push_exp(32'd0, 1'b0);
    give_done(4);
    wait_start(100, "w_const_hi");
    sig_level = 1'b0;
    sig_epoch++;
    push_exp(32'd0, 1'b0);
    give_done(4);
    wait_start(100, "w_const_lo");
    en = 1'b0;
    cycles(10);
    chk("sb_drained", exp_bin_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
